// File: rtl/alu_pkg.sv
// Shared opcode and state encodings for the sequential ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOR  = 4'd5,
    OP_SLT  = 4'd6,
    OP_SLTU = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10,
    OP_MUL  = 4'd11,
    OP_DIVU = 4'd12,
    OP_REMU = 4'd13
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_iter.sv
// Iterative datapath: shift-add multiply and restoring divide, one bit per cycle for W cycles.
module alu_iter
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] tr,
  input  logic [W-1:0] sr,
  output logic         done,
  output logic [W-1:0] result,
  output logic         ovf
);

  localparam int CW = $clog2(W);

  logic         busy;
  logic [CW-1:0] cnt;
  logic         is_mul;
  logic         is_rem;
  logic [W-1:0] acc;   // product high half / partial remainder
  logic [W-1:0] quo;   // multiplier bits / dividend-then-quotient bits
  logic [W-1:0] opb;   // multiplicand / divisor
  logic [W-1:0] acc_n;
  logic [W-1:0] quo_n;
  logic [W:0]   sum;
  logic [W:0]   sh;
  logic [W-1:0] diff;

  // NOTE: every signal driven here gets a value on every path; a missed default infers a latch.
  always_comb begin
    sum  = {1'b0, acc} + (quo[0] ? {1'b0, opb} : '0);
    sh   = {acc, quo[W-1]};
    diff = sh[W-1:0] - opb;
    if (is_mul) begin
      acc_n = sum[W:1];
      quo_n = {sum[0], quo[W-1:1]};
    end else if (sh >= {1'b0, opb}) begin
      acc_n = diff;
      quo_n = {quo[W-2:0], 1'b1};
    end else begin
      acc_n = sh[W-1:0];
      quo_n = {quo[W-2:0], 1'b0};
    end
  end

  // Outputs reflect the step being taken this cycle, so the final step is visible with done.
  assign done   = busy && (cnt == CW'(W - 1));
  assign result = is_rem ? acc_n : quo_n;
  assign ovf    = is_mul ? (acc_n != '0) : (opb == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

  // NOTE: datapath registers carry no reset; busy gates every use of them.
  always_ff @(posedge clk) begin
    if (start) begin
      is_mul <= (op == OP_MUL);
      is_rem <= (op == OP_REMU);
      acc    <= '0;
      quo    <= (op == OP_MUL) ? sr : tr;
      opb    <= (op == OP_MUL) ? tr : sr;
    end else if (busy) begin
      acc <= acc_n;
      quo <= quo_n;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops complete next cycle, MUL/DIVU/REMU iterate W cycles.
module alu_seq
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [W-1:0] tr,
  input  logic [W-1:0] sr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] dr,
  output logic         cf,
  output logic         of,
  output logic         zf
);

  localparam int SW = $clog2(W);

  state_e        state;
  logic          accept;
  logic          start;
  logic          iter_done;
  logic          iter_ovf;
  logic [W-1:0]  iter_res;
  logic [W-1:0]  alu_res;
  logic          alu_cf;
  logic          alu_of;
  logic [W:0]    add_w;
  logic [W:0]    sub_w;
  logic [SW-1:0] shamt;

  assign accept = in_valid && in_ready;
  assign start  = accept && is_iter_op(op);
  assign shamt  = sr[SW-1:0];
  assign add_w  = {1'b0, tr} + {1'b0, sr};
  assign sub_w  = {1'b0, tr} - {1'b0, sr};

  always_comb begin
    alu_res = '0;
    alu_cf  = 1'b0;
    alu_of  = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = add_w[W-1:0];
        alu_cf  = add_w[W];
        alu_of  = (tr[W-1] == sr[W-1]) && (add_w[W-1] != tr[W-1]);
      end
      OP_SUB: begin
        alu_res = sub_w[W-1:0];
        alu_cf  = sub_w[W];
        alu_of  = (tr[W-1] != sr[W-1]) && (sub_w[W-1] != tr[W-1]);
      end
      OP_AND:  alu_res = tr & sr;
      OP_OR:   alu_res = tr | sr;
      OP_XOR:  alu_res = tr ^ sr;
      OP_NOR:  alu_res = ~(tr | sr);
      OP_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(tr) < $signed(sr))};
      OP_SLTU: alu_res = {{(W-1){1'b0}}, (tr < sr)};
      OP_SLL:  alu_res = tr << shamt;
      OP_SRL:  alu_res = tr >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(tr) >>> shamt);
      OP_MUL, OP_DIVU, OP_REMU: ;
      default: alu_of = 1'b1;  // illegal opcodes 14/15
    endcase
  end

  alu_iter #(.W(W)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .tr     (tr),
    .sr     (sr),
    .done   (iter_done),
    .result (iter_res),
    .ovf    (iter_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      dr        <= '0;
      cf        <= 1'b0;
      of        <= 1'b0;
      zf        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (is_iter_op(op)) begin
              state <= ITER;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              dr        <= alu_res;
              cf        <= alu_cf;
              of        <= alu_of;
              zf        <= (alu_res == '0);
            end
          end
        end
        ITER: begin
          if (iter_done) begin
            state     <= DONE;
            out_valid <= 1'b1;
            dr        <= iter_res;
            cf        <= 1'b0;
            of        <= iter_ovf;
            zf        <= (iter_res == '0);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter W, 32, operand/result width in bits; legal values are powers of two, 8 to 64.
REQ-002 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1, reset: synchronous and active-high.
REQ-004 Port in_valid, input, 1, an operation is presented on op/tr/sr.
REQ-005 Port in_ready, output, 1, the block accepts an operation this cycle.
REQ-006 Port op, input, 4, opcode.
REQ-007 Port tr, input, W, first operand.
REQ-008 Port sr, input, W, second operand; for shifts, only bits [log2(W)-1:0] are used.
REQ-009 Port out_valid, output, 1, dr and the flags hold a completed result.
REQ-010 Port out_ready, input, 1, the consumer takes the result this cycle.
REQ-011 Port dr, output, W, result.
REQ-012 Ports cf/of/zf, output, 1 each: carry-or-borrow flag, overflow or divide-by-zero flag, result-is-zero flag.

Function
REQ-013 Opcodes SHALL be assigned as follows:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR
- 6 SLT (signed less-than), 7 SLTU (unsigned less-than)
- 8 SLL, 9 SRL, 10 SRA
- 11 MUL (low W bits of the product), 12 DIVU (quotient), 13 REMU (remainder)
- 14 and 15 illegal
REQ-014 An operation SHALL be accepted on any cycle where in_valid and in_ready are both high; operands and op are captured on that cycle.
REQ-015 The state machine SHALL have three states:
- IDLE: in_ready=1.
- ITER: in_ready=0, out_valid=0.
- DONE: in_ready=0, out_valid=1.
REQ-016 Single-cycle opcodes (0-10, 14, 15) SHALL move IDLE to DONE, so out_valid rises on the cycle after acceptance.
REQ-017 Opcodes 11-13 SHALL move IDLE to ITER. ITER runs exactly W cycles, then moves to DONE, so out_valid rises W+1 cycles after acceptance.
REQ-018 DONE SHALL move to IDLE on the cycle where out_ready is high. While out_ready is low, dr/cf/of/zf SHALL hold stable.
REQ-019 Acceptance SHALL NOT overlap a pending result; a new operation can be accepted no earlier than the cycle after the DONE handshake.
REQ-020 For ADD, cf SHALL equal the unsigned carry-out and of SHALL equal the two's-complement signed overflow.
REQ-021 For SUB, cf SHALL equal the borrow (1 when tr<sr unsigned) and of SHALL equal the signed overflow.
REQ-022 All other opcodes SHALL drive cf=0. For every opcode, zf SHALL equal (dr==0).
REQ-023 SLT and SLTU SHALL drive dr to 1 when true and 0 when false.
REQ-024 SRA SHALL replicate tr[W-1]. A shift amount of 0 SHALL return tr unchanged.
REQ-025 MUL SHALL use the shift-add algorithm and return the low W bits. of SHALL be 1 when the upper W bits of the full product are nonzero.
REQ-026 DIVU and REMU SHALL use the restoring algorithm. When sr==0, quotient SHALL be all ones, remainder SHALL be tr, and of=1, still after W iterations.
REQ-027 Illegal opcodes SHALL produce dr=0, zf=1, cf=0, of=1.

Reset
REQ-028 While rst is high at a clock edge, the block SHALL enter IDLE and force out_valid=0, in_ready=1, dr=0, cf=0, of=0, zf=0.
REQ-029 A reset during ITER or DONE SHALL discard the operation; no result is ever presented for it.
REQ-030 When rst and in_valid are high on the same cycle, the operation SHALL NOT be accepted.

Structure
REQ-031 Package alu_pkg SHALL hold the opcode constants and the IDLE/ITER/DONE state encoding.
REQ-032 Iterative MUL/DIVU/REMU datapath SHALL live in one sub-module, alu_iter:
- inputs: start, op, operands
- outputs: count-done pulse, result, overflow
REQ-033 The single-cycle datapath SHALL be combinational logic in alu_seq, registered into dr on the transition to DONE.

Verification (W=32, out_ready=1 unless stated)
REQ-034 ADD tr=32 sr=21: dr=53, cf=0, of=0, zf=0, out_valid one cycle after acceptance.
REQ-035 Signed and unsigned edge cases:
- SUB tr=21 sr=32: dr=0xFFFFFFF5, cf=1, of=0.
- ADD tr=0x7FFFFFFF sr=1: dr=0x80000000, of=1.
REQ-036 Shifts:
- SLL tr=32 sr=3: dr=256.
- SRA tr=0x80000000 sr=3: dr=0xF0000000.
- SRL with the same operands: dr=0x10000000.
- SLL sr=35: dr=256 (only the low 5 bits of sr are used).
REQ-037 Iterative operations:
- MUL tr=32 sr=21: dr=672, of=0, out_valid exactly 33 cycles after acceptance.
- DIVU tr=32 sr=0: dr=0xFFFFFFFF, of=1.
- REMU tr=32 sr=5: dr=2.
REQ-038 Backpressure: hold out_ready=0 for 5 cycles after ADD completes; dr stays 53 and in_ready stays 0. Raise out_ready; in_ready=1 on the next cycle.
REQ-039 Reset mid-operation: assert rst on cycle 10 of a MUL. out_valid never rises for it, and in_ready=1 on the cycle after rst deasserts.
